// File: rtl/opimul_arb.sv
// Round-robin arbiter sharing one opimul pool between NREQ requesters.
// Issue and return paths are combinational; a tag FIFO routes in-order results home.
module opimul_arb #(
    parameter int ARCHBITSZ = 16,
    parameter int GPRCNT    = 32,
    parameter int NREQ      = 2,
    parameter int TAGDEPTH  = 2,
    localparam int CLOG2GPRCNT = $clog2(GPRCNT),
    localparam int DBITSZ      = ARCHBITSZ*2 + CLOG2GPRCNT + 2,
    localparam int TAGBITSZ    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NREQ-1:0]          req_stb_i,
    input  logic [NREQ*DBITSZ-1:0]   req_data_i,
    output logic [NREQ-1:0]          req_rdy_o,
    output logic [NREQ-1:0]          rsp_rdy_o,
    input  logic [NREQ-1:0]          rsp_stb_i,
    output logic [ARCHBITSZ-1:0]     rsp_data_o,
    output logic [CLOG2GPRCNT-1:0]   rsp_gprid_o,
    output logic                     m_stb_o,
    output logic [DBITSZ-1:0]        m_data_o,
    input  logic                     m_rdy_i,
    output logic                     m_ostb_o,
    input  logic [ARCHBITSZ-1:0]     m_data_i,
    input  logic [CLOG2GPRCNT-1:0]   m_gprid_i,
    input  logic                     m_ordy_i
);

    localparam int AW = $clog2(TAGDEPTH);

    logic [TAGBITSZ-1:0] ptr;
    logic [TAGBITSZ-1:0] grant;
    logic [TAGBITSZ-1:0] ptr_next;
    logic [TAGBITSZ-1:0] head;
    logic [AW:0]         wr_idx;
    logic [AW:0]         rd_idx;
    logic [AW:0]         count;
    logic [TAGBITSZ-1:0] tag_mem [TAGDEPTH];
    logic                found;
    logic                full;
    logic                empty;
    logic                fire;
    logic                pop;
    int                  j;

    // Rotating priority scan starting at ptr; first requester found wins.
    // NOTE: combinational logic uses blocking '=' with every output defaulted
    // first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        grant = ptr;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req_stb_i[j]) begin
                grant = TAGBITSZ'(j);
                found = 1'b1;
            end
        end
    end

    assign ptr_next = (grant == TAGBITSZ'(NREQ-1)) ? '0 : grant + TAGBITSZ'(1);

    assign count = wr_idx - rd_idx;
    assign full  = (count == (AW+1)'(TAGDEPTH));
    assign empty = (count == '0);
    assign head  = tag_mem[rd_idx[AW-1:0]];

    assign m_stb_o   = !rst_i && (|req_stb_i) && !full;
    assign m_data_o  = req_data_i[grant*DBITSZ +: DBITSZ];
    assign fire      = m_stb_o && m_rdy_i;
    assign req_rdy_o = fire ? (NREQ'(1) << grant) : '0;

    // Result at the FIFO head is offered only to its owner; others' strobes are ignored.
    assign rsp_rdy_o   = (!rst_i && m_ordy_i && !empty) ? (NREQ'(1) << head) : '0;
    assign m_ostb_o    = |(rsp_stb_i & rsp_rdy_o);
    assign pop         = m_ordy_i && m_ostb_o;
    assign rsp_data_o  = m_data_i;
    assign rsp_gprid_o = m_gprid_i;

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr    <= '0;
            wr_idx <= '0;
            rd_idx <= '0;
        end else begin
            if (fire) begin
                ptr    <= ptr_next;
                wr_idx <= wr_idx + (AW+1)'(1);
            end
            if (pop) begin
                rd_idx <= rd_idx + (AW+1)'(1);
            end
        end
    end

    // NOTE: tag storage is deliberately not reset; the indices alone decide
    // which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        if (fire) tag_mem[wr_idx[AW-1:0]] <= grant;
    end

endmodule
